// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Write-port scheduler and busy scoreboard for the single-write-port register_file.
//   Two writeback sources (A: ALU, B: load unit) share the one regwr/rd/rddata port
//   under round-robin arbitration. A per-register busy scoreboard keeps the issue
//   stage from reserving a destination that still has a pending writer.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   a_valid/a_ready/a_rd/a_data   source A writeback handshake
//   b_valid/b_ready/b_rd/b_data   source B writeback handshake
//   issue_valid/issue_ready/issue_rd  destination reservation handshake
//   regwr/rd/rddata               registered write port to register_file
//   busy                          scoreboard, bit i = register i has a pending writer
//   wb_err                        (only with REGFILE_WB_CHECK_EN) sticky flag, a writeback
//                                 hit a non-zero register that was not reserved
//
// Build option: define REGFILE_WB_CHECK_EN to add the wb_err output and its checker.

module regfile_wb_scheduler #(
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned WORDSIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ADDRSIZE-1:0]    a_rd,
  input  logic [WORDSIZE-1:0]    a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [ADDRSIZE-1:0]    b_rd,
  input  logic [WORDSIZE-1:0]    b_data,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [ADDRSIZE-1:0]    issue_rd,
  output logic                   regwr,
  output logic [ADDRSIZE-1:0]    rd,
  output logic [WORDSIZE-1:0]    rddata,
`ifdef REGFILE_WB_CHECK_EN
  output logic                   wb_err,
`endif
  output logic [2**ADDRSIZE-1:0] busy
);

  // Round-robin pointer encoding: which source was granted most recently.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  logic                   last_q, last_d;
  logic                   grant_a, grant_b;
  logic                   wb_hs, wb_live;
  logic [ADDRSIZE-1:0]    wb_rd;
  logic [WORDSIZE-1:0]    wb_data;
  logic                   issue_hs, issue_live;
  logic [2**ADDRSIZE-1:0] busy_q, busy_d;
  logic                   regwr_q;
  logic [ADDRSIZE-1:0]    rd_q;
  logic [WORDSIZE-1:0]    rddata_q;

  // Grants are combinational; on a tie the source that did not win last time goes.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        grant_a = (last_q == SRC_B);
        grant_b = !grant_a;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign wb_hs   = grant_a || grant_b;
  assign wb_rd   = grant_a ? a_rd   : b_rd;
  assign wb_data = grant_a ? a_data : b_data;
  // x0 writebacks are consumed but never reach the register file or the scoreboard.
  assign wb_live = wb_hs && (wb_rd != '0);

  assign issue_ready = !rst && (!busy_q[issue_rd] || (issue_rd == '0));
  assign issue_hs    = issue_valid && issue_ready;
  assign issue_live  = issue_hs && (issue_rd != '0);

  always_comb begin
    last_d = last_q;
    if (wb_hs) begin
      last_d = grant_a ? SRC_A : SRC_B;
    end
  end

  // Clear and set never hit the same index: issue_ready is low while a bit is set.
  always_comb begin
    busy_d = busy_q;
    if (wb_live) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_live) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= SRC_B;
      regwr_q  <= 1'b0;
      rd_q     <= '0;
      rddata_q <= '0;
      busy_q   <= '0;
    end else begin
      last_q  <= last_d;
      regwr_q <= wb_live;
      busy_q  <= busy_d;
      if (wb_live) begin
        rd_q     <= wb_rd;
        rddata_q <= wb_data;
      end
    end
  end

  assign regwr  = regwr_q;
  assign rd     = rd_q;
  assign rddata = rddata_q;
  assign busy   = busy_q;

`ifdef REGFILE_WB_CHECK_EN
  logic wb_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_err_q <= 1'b0;
    end else if (wb_live && !busy_q[wb_rd]) begin
      wb_err_q <= 1'b1;
    end
  end

  assign wb_err = wb_err_q;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized bench for regfile_wb_scheduler. The driver computes expected readys and
// scoreboard state from a simple reference model and queues each accepted writeback;
// a separate monitor pops the queue and checks the register-file write port.

module tb_regfile_wb_scheduler;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_ready, b_valid, b_ready, issue_valid, issue_ready;
  logic [AW-1:0] a_rd, b_rd, issue_rd, rd;
  logic [DW-1:0] a_data, b_data, rddata;
  logic          regwr;
  logic [NR-1:0] busy;
`ifdef REGFILE_WB_CHECK_EN
  logic          wb_err;
`endif

  regfile_wb_scheduler #(.ADDRSIZE(AW), .WORDSIZE(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .regwr(regwr), .rd(rd), .rddata(rddata),
`ifdef REGFILE_WB_CHECK_EN
    .wb_err(wb_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t expq[$];
  int  errors = 0;
  int  checks = 0;
  logic done = 1'b0;

  // Reference state
  bit [NR-1:0] mbusy;
  int          mlast;   // 0 = A granted last, 1 = B granted last
  bit          merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected write per accepted handshake, exactly one cycle later.
  initial begin : monitor
    logic [AW-1:0] exp_rd;
    logic [DW-1:0] exp_data;
    bit            known;
    wb_t           e;
    exp_rd = '0;
    exp_data = '0;
    known = 1'b1;
    while (!done) begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_rd = '0;
        exp_data = '0;
        known = 1'b1;
        chk("regwr_in_reset", {31'b0, regwr}, 32'd0);
      end else if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.rd != '0) begin
          chk("regwr", {31'b0, regwr}, 32'd1);
          chk("rd", {28'b0, rd}, {28'b0, e.rd});
          chk("rddata", {24'b0, rddata}, {24'b0, e.data});
          exp_rd = e.rd;
          exp_data = e.data;
          known = 1'b1;
        end else begin
          chk("regwr_x0", {31'b0, regwr}, 32'd0);
          known = 1'b0;
        end
      end else begin
        chk("regwr_idle", {31'b0, regwr}, 32'd0);
        if (known) begin
          chk("rd_hold", {28'b0, rd}, {28'b0, exp_rd});
          chk("rddata_hold", {24'b0, rddata}, {24'b0, exp_data});
        end
      end
    end
  end

  initial begin : driver
    bit exp_a, exp_b, exp_i;
    logic [AW-1:0] wrd;
    logic [DW-1:0] wdata;
    mbusy = '0;
    mlast = 1;
    merr = 1'b0;
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
    a_rd = '0; b_rd = '0; issue_rd = '0; a_data = '0; b_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      chk("busy", {16'b0, busy}, {16'b0, mbusy});
`ifdef REGFILE_WB_CHECK_EN
      chk("wb_err", {31'b0, wb_err}, {31'b0, merr});
`endif
      a_valid     = ($urandom_range(2) != 0);
      b_valid     = ($urandom_range(2) != 0);
      issue_valid = ($urandom_range(2) != 0);
      a_rd        = AW'($urandom_range(NR - 1));
      b_rd        = AW'($urandom_range(NR - 1));
      issue_rd    = AW'($urandom_range(NR - 1));
      a_data      = DW'($urandom_range(255));
      b_data      = DW'($urandom_range(255));
      // Bias writebacks towards reserved registers so the scoreboard drains.
      if ($urandom_range(3) != 0) begin
        for (int k = 0; k < NR; k++) if (mbusy[k]) begin a_rd = AW'(k); break; end
        for (int k = NR - 1; k > 0; k--) if (mbusy[k]) begin b_rd = AW'(k); break; end
      end
      #1;

      // Expected arbitration from the reference model.
      exp_a = a_valid && (!b_valid || mlast == 1);
      exp_b = b_valid && (!a_valid || mlast == 0);
      exp_i = (mbusy[issue_rd] == 1'b0) || (issue_rd == 0);
      chk("a_ready", {31'b0, a_ready}, {31'b0, exp_a});
      chk("b_ready", {31'b0, b_ready}, {31'b0, exp_b});
      chk("issue_ready", {31'b0, issue_ready}, {31'b0, exp_i});

      if (exp_a || exp_b) begin
        wrd   = exp_a ? a_rd : b_rd;
        wdata = exp_a ? a_data : b_data;
        mlast = exp_a ? 0 : 1;
        expq.push_back('{rd: wrd, data: wdata});
        if (wrd != 0) begin
          if (!mbusy[wrd]) merr = 1'b1;
          mbusy[wrd] = 1'b0;
        end
      end
      if (issue_valid && exp_i && issue_rd != 0) mbusy[issue_rd] = 1'b1;

      // Occasional reset landing after a handshake but before the capturing edge.
      if ($urandom_range(59) == 0) begin
        rst = 1'b1;
        #1;
        chk("a_ready_rst", {31'b0, a_ready}, 32'd0);
        chk("b_ready_rst", {31'b0, b_ready}, 32'd0);
        chk("issue_ready_rst", {31'b0, issue_ready}, 32'd0);
        expq.delete();
        mbusy = '0;
        mlast = 1;
        merr = 1'b0;
      end
    end

    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; issue_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", expq.size(), 32'd0);
    done = 1'b1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
